// File: rtl/spi_ram_arbiter_if.sv
// Signal bundle between spi_ram_arbiter, the spi_slave command side, the local
// requester and the single-port RAM. The arbiter connects through the slave modport.
interface spi_ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [9:0]        rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;

  logic              loc_req;
  logic              loc_we;
  logic [ADDR_W-1:0] loc_addr;
  logic [DATA_W-1:0] loc_wdata;
  logic              loc_gnt;
  logic [DATA_W-1:0] loc_rdata;
  logic              loc_rvalid;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              spi_ovf;

  modport slave (
    input  rx_data, rx_valid,
    input  loc_req, loc_we, loc_addr, loc_wdata,
    input  ram_rdata,
    output tx_data, tx_valid,
    output loc_gnt, loc_rdata, loc_rvalid,
    output ram_en, ram_we, ram_addr, ram_wdata,
    output spi_ovf
  );

  modport master (
    output rx_data, rx_valid,
    output loc_req, loc_we, loc_addr, loc_wdata,
    output ram_rdata,
    input  tx_data, tx_valid,
    input  loc_gnt, loc_rdata, loc_rvalid,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    input  spi_ovf
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Decodes spi_slave command words into RAM accesses and shares the RAM with a
// local requester under round-robin arbitration; one access per issue cycle.
module spi_ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RD_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_REQ  = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_REQ  = 2'b11;

  state_t            state_r;
  logic              rx_valid_q_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [ADDR_W-1:0] rd_addr_r;

  logic              spi_pend_r;
  logic              spi_we_r;
  logic [ADDR_W-1:0] spi_addr_r;
  logic [DATA_W-1:0] spi_wdata_r;
  logic              spi_ovf_r;

  logic              last_spi_r;
  logic              cur_loc_r;

  logic              ram_en_r;
  logic              ram_we_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic [DATA_W-1:0] ram_wdata_r;
  logic              loc_gnt_r;
  logic [DATA_W-1:0] loc_rdata_r;
  logic              loc_rvalid_r;
  logic [DATA_W-1:0] tx_data_r;
  logic              tx_valid_r;

  logic              accept_s;
  logic [1:0]        opcode_s;
  logic [7:0]        payload_s;
  logic              spi_cmd_s;
  logic              pick_spi_s;
  logic              pick_loc_s;

  // Rising-edge command detect and round-robin winner selection while idle
  always_comb begin
    accept_s   = bus.rx_valid & ~rx_valid_q_r;
    opcode_s   = bus.rx_data[9:8];
    payload_s  = bus.rx_data[7:0];
    spi_cmd_s  = accept_s & opcode_s[0];
    pick_spi_s = 1'b0;
    pick_loc_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (spi_pend_r && bus.loc_req) begin
        // last_spi_r=0 means the local port won last (its reset value)
        if (last_spi_r) begin
          pick_loc_s = 1'b1;
        end else begin
          pick_spi_s = 1'b1;
        end
      end else if (spi_pend_r) begin
        pick_spi_s = 1'b1;
      end else if (bus.loc_req) begin
        pick_loc_s = 1'b1;
      end else begin
        pick_spi_s = 1'b0;
        pick_loc_s = 1'b0;
      end
    end else begin
      pick_spi_s = 1'b0;
      pick_loc_s = 1'b0;
    end
  end

  // Command decode: address registers, the single SPI pending slot and overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q_r <= 1'b0;
      wr_addr_r    <= {ADDR_W{1'b0}};
      rd_addr_r    <= {ADDR_W{1'b0}};
      spi_pend_r   <= 1'b0;
      spi_we_r     <= 1'b0;
      spi_addr_r   <= {ADDR_W{1'b0}};
      spi_wdata_r  <= {DATA_W{1'b0}};
      spi_ovf_r    <= 1'b0;
    end else begin
      rx_valid_q_r <= bus.rx_valid;
      if (accept_s) begin
        case (opcode_s)
          OP_WR_ADDR: wr_addr_r <= payload_s;
          OP_RD_ADDR: rd_addr_r <= payload_s;
          default:    wr_addr_r <= wr_addr_r;
        endcase
      end
      // The pending slot is released in the decision cycle, so an accept in
      // that same cycle refills it without counting as an overflow.
      if (spi_cmd_s) begin
        spi_pend_r <= 1'b1;
        spi_we_r   <= (opcode_s == OP_WR_REQ);
        if (opcode_s == OP_RD_REQ) begin
          spi_addr_r <= rd_addr_r;
        end else begin
          spi_addr_r  <= wr_addr_r;
          spi_wdata_r <= payload_s;
        end
        if (spi_pend_r && !pick_spi_s) begin
          spi_ovf_r <= 1'b1;
        end
      end else if (pick_spi_s) begin
        spi_pend_r <= 1'b0;
      end
    end
  end

  // Arbitration FSM with registered RAM strobes, grant and read responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      last_spi_r   <= 1'b0;
      cur_loc_r    <= 1'b0;
      ram_en_r     <= 1'b0;
      ram_we_r     <= 1'b0;
      ram_addr_r   <= {ADDR_W{1'b0}};
      ram_wdata_r  <= {DATA_W{1'b0}};
      loc_gnt_r    <= 1'b0;
      loc_rdata_r  <= {DATA_W{1'b0}};
      loc_rvalid_r <= 1'b0;
      tx_data_r    <= {DATA_W{1'b0}};
      tx_valid_r   <= 1'b0;
    end else begin
      ram_en_r     <= 1'b0;
      loc_gnt_r    <= 1'b0;
      loc_rvalid_r <= 1'b0;
      if (accept_s) begin
        tx_valid_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (pick_spi_s) begin
            ram_en_r    <= 1'b1;
            ram_we_r    <= spi_we_r;
            ram_addr_r  <= spi_addr_r;
            ram_wdata_r <= spi_wdata_r;
            last_spi_r  <= 1'b1;
            cur_loc_r   <= 1'b0;
            state_r     <= ST_ISSUE;
          end else if (pick_loc_s) begin
            ram_en_r    <= 1'b1;
            ram_we_r    <= bus.loc_we;
            ram_addr_r  <= bus.loc_addr;
            ram_wdata_r <= bus.loc_wdata;
            loc_gnt_r   <= 1'b1;
            last_spi_r  <= 1'b0;
            cur_loc_r   <= 1'b1;
            state_r     <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state_r <= ram_we_r ? ST_IDLE : ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (cur_loc_r) begin
            loc_rdata_r  <= bus.ram_rdata;
            loc_rvalid_r <= 1'b1;
          end else begin
            tx_data_r  <= bus.ram_rdata;
            tx_valid_r <= 1'b1;
          end
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ram_en     = ram_en_r;
  assign bus.ram_we     = ram_we_r;
  assign bus.ram_addr   = ram_addr_r;
  assign bus.ram_wdata  = ram_wdata_r;
  assign bus.loc_gnt    = loc_gnt_r;
  assign bus.loc_rdata  = loc_rdata_r;
  assign bus.loc_rvalid = loc_rvalid_r;
  assign bus.tx_data    = tx_data_r;
  assign bus.tx_valid   = tx_valid_r;
  assign bus.spi_ovf    = spi_ovf_r;

endmodule
